fp_to_fixed_conv: RTL
=====================

Name: fp_to_fixed_conv

Overview:
Converts IEEE-754 single-precision operands (as produced by the FFT float adder/butterfly datapath) back into signed two's-complement fixed-point with FRAC_BITS fractional bits. It is the float-decode end of the FFT output path, feeding fixed-point consumers such as the DAC, magnitude and scaling logic. Alignment is done serially, one bit position per cycle, under a small FSM. A valid/ready handshake is used on both sides, with one transaction in flight.

Parameters:
OUT_W, 32, output word width in bits (legal range 25..40)
FRAC_BITS, 15, number of fractional bits in out_data

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_data is valid
in_ready  output  1  block can accept an operand
in_data  input  32  IEEE-754 single: [31] sign, [30:23] exponent, [22:0] fraction
out_valid  output  1  out_data and out_ovf are valid
out_ready  input  1  consumer accepts the result
out_data  output  OUT_W  signed fixed-point result
out_ovf  output  1  result was saturated, or the input was NaN

Behaviour:
- Reset, asynchronous while rst_n=0: state=IDLE, out_valid=0, out_data=0, out_ovf=0, in_ready=1 after release. Reset mid-conversion discards the operand; no partial result is ever presented.
- in_ready=1 only in IDLE. An operand is accepted on the edge where in_valid && in_ready.
- Decode at acceptance:
  - e=in_data[30:23]; mant={1,in_data[22:0]} (24 bits).
  - s = e - 127 + FRAC_BITS - 23, computed signed with at least 10 bits.
- Classification at acceptance (priority order):
  - e=0 (zero or denormal): result 0, ovf=0, cnt=0.
  - e=255 with fraction≠0 (NaN): result 0, ovf=1, cnt=0.
  - e=255 with fraction=0 (Inf): saturate by sign, ovf=1, cnt=0.
  - 23+s >= OUT_W-1: saturate by sign, ovf=1, cnt=0. This applies even to an exact -2^(OUT_W-1).
  - -s > 24: result 0, ovf=0, cnt=0.
  - otherwise: mag=mant, direction=sign(s), cnt=|s|.
- Saturation values: positive 2^(OUT_W-1)-1; negative -2^(OUT_W-1).
- FSM:
  - IDLE: on accept, go to SHIFT with cnt loaded.
  - SHIFT: while cnt>0, shift mag one bit (left if s>0, else right; zeros are shifted in) and decrement cnt. When cnt=0, go to FINISH.
  - FINISH: apply sign (two's complement if in_data[31]=1 and not saturated), register out_data and out_ovf, go to DONE.
  - DONE: out_valid=1. out_data and out_ovf are held stable until out_ready=1; on that edge go to IDLE with out_valid=0.
- Latency and throughput:
  - out_valid rises cnt+2 cycles after the accept edge.
  - Special and saturating cases take 2 cycles.
  - After the out_ready handshake, in_ready returns one cycle later, so back-to-back throughput is 1 result per cnt+4 cycles.
- Right shifts truncate the magnitude, i.e. round toward zero. Left shifts never lose bits, because overflow is pre-checked.
- -0.0 produces 0 with ovf=0.
- in_data is sampled only at acceptance; changes to it afterwards are ignored.

Optional Feature:
Macro FP2FIX_ROUND_EN.
- Defined: a guard register captures the last bit shifted out on right shifts. In FINISH, magnitude += guard (round half away from zero) before sign is applied. Rounding cannot overflow, because the magnitude is below 2^24.
- Undefined: no guard register; truncation toward zero.

Decomposition:
- Package fft_fp_pkg holds:
  - FP_EXP_BIAS=127, FP_MANT_W=24, FP_EXP_W=8
  - fsm state typedef {IDLE, SHIFT, FINISH, DONE}
  - IEEE-754 field-slice constants, shared with the adder.
- One sub-module, fp_classify: combinational decode of the exponent and fraction fields into a zero/NaN/Inf/normal class, plus the signed shift s. It is reusable by the adder's zero handling.

Test Plan:
- 0x3F800000 (1.0), defaults -> out_data=0x00008000, ovf=0, out_valid 10 cycles after accept.
- 0xC0200000 (-2.5) -> out_data=0xFFFEC000, ovf=0, latency 9.
- 0x47800000 (65536.0) and 0x7F800000 (+Inf) -> 0x7FFFFFFF, ovf=1, latency 2; 0xFF800000 (-Inf) -> 0x80000000, ovf=1; 0x7FC00000 (NaN) -> 0x00000000, ovf=1.
- 0x37C00000 (1.5*2^-16) -> 0x00000000 without FP2FIX_ROUND_EN, 0x00000001 with it; 0x80000000 (-0.0) and 0x35800000 (2^-20) -> 0, latency 2.
- Backpressure: hold out_ready=0 for 20 cycles in DONE -> out_data stable, in_ready=0; then assert out_ready -> in_ready=1 on the next cycle.
- Assert rst_n=0 during SHIFT of 1.0 -> out_valid=0 immediately; after release, a new operand 0x40000000 (2.0) converts to 0x00010000.

Source files
------------

// File: rtl/fft_fp_pkg.sv
// ============================================================================
// Module   : fft_fp_pkg
// Brief    : IEEE-754 single-precision field layout, converter FSM states and
//            float class codes shared by the FFT float datapath blocks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fft_fp_pkg;

    localparam int FP_EXP_BIAS = 127;
    localparam int FP_MANT_W   = 24;
    localparam int FP_EXP_W    = 8;
    localparam int FP_SHIFT_W  = 10;

    localparam int FP_SIGN_BIT = 31;
    localparam int FP_EXP_MSB  = 30;
    localparam int FP_EXP_LSB  = 23;
    localparam int FP_FRAC_MSB = 22;
    localparam int FP_FRAC_LSB = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2,
        DONE   = 2'd3
    } fsm_state_t;

    typedef enum logic [1:0] {
        FP_ZERO   = 2'd0,
        FP_NAN    = 2'd1,
        FP_INF    = 2'd2,
        FP_NORMAL = 2'd3
    } fp_class_t;

    // Restores the hidden leading one of a normal number.
    function automatic logic [FP_MANT_W-1:0] fp_mant(input logic [FP_MANT_W-2:0] frac);
        return {1'b1, frac};
    endfunction

endpackage

`default_nettype wire

// File: rtl/fp_classify.sv
// ============================================================================
// Module   : fp_classify
// Brief    : Combinational decode of IEEE-754 exponent/fraction into a
//            zero/NaN/Inf/normal class and the signed alignment shift.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_classify
    import fft_fp_pkg::*;
#(
    parameter int FRAC_BITS = 15
) (
    input  logic [FP_EXP_W-1:0]          i_exp,
    input  logic [FP_MANT_W-2:0]         i_frac,
    output fp_class_t                    o_class,
    output logic signed [FP_SHIFT_W-1:0] o_shift
);

    // Net shift from the mantissa LSB weight to the fixed-point LSB weight.
    localparam logic signed [FP_SHIFT_W-1:0] C_SHIFT_OFS =
        FP_SHIFT_W'(FRAC_BITS - (FP_MANT_W - 1) - FP_EXP_BIAS);

    always_comb begin
        o_class = FP_NORMAL;
        if (i_exp == '0) begin
            o_class = FP_ZERO;
        end else if (i_exp == '1) begin
            o_class = (i_frac != '0) ? FP_NAN : FP_INF;
        end
    end

    assign o_shift = $signed({{(FP_SHIFT_W - FP_EXP_W){1'b0}}, i_exp}) + C_SHIFT_OFS;

endmodule

`default_nettype wire

// File: rtl/fp_to_fixed_conv.sv
// ============================================================================
// Module   : fp_to_fixed_conv
// Brief    : Serial IEEE-754 single to signed fixed-point converter, one bit
//            of alignment per cycle. Define FP2FIX_ROUND_EN for round half
//            away from zero instead of truncation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_to_fixed_conv
    import fft_fp_pkg::*;
#(
    parameter int OUT_W     = 32,
    parameter int FRAC_BITS = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ovf
);

    localparam logic [OUT_W-1:0] C_SAT_POS = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] C_SAT_NEG = {1'b1, {(OUT_W-1){1'b0}}};

    fsm_state_t r_state;
    fsm_state_t w_state_nxt;

    logic                         w_sign;
    logic [FP_EXP_W-1:0]          w_exp;
    logic [FP_MANT_W-2:0]         w_frac;
    fp_class_t                    w_class;
    logic signed [FP_SHIFT_W-1:0] w_shift;
    logic signed [31:0]           w_shift_ext;
    logic [FP_SHIFT_W-1:0]        w_abs;
    logic                         w_ovr_range;
    logic                         w_udr_range;
    logic                         w_special;
    logic [OUT_W-1:0]             w_spec_val;
    logic                         w_spec_ovf;
    logic                         w_accept;
    logic [OUT_W-1:0]             w_mag_fin;
    logic [OUT_W-1:0]             w_result;

    logic [OUT_W-1:0]      r_mag;
    logic [FP_SHIFT_W-1:0] r_cnt;
    logic                  r_left;
    logic                  r_neg;
    logic                  r_special;
    logic                  r_ovf;
    logic [OUT_W-1:0]      r_out_data;
    logic                  r_out_ovf;

    assign w_sign = in_data[FP_SIGN_BIT];
    assign w_exp  = in_data[FP_EXP_MSB:FP_EXP_LSB];
    assign w_frac = in_data[FP_FRAC_MSB:FP_FRAC_LSB];

    fp_classify #(
        .FRAC_BITS (FRAC_BITS)
    ) u_classify (
        .i_exp   (w_exp),
        .i_frac  (w_frac),
        .o_class (w_class),
        .o_shift (w_shift)
    );

    assign w_shift_ext = $signed({{(32-FP_SHIFT_W){w_shift[FP_SHIFT_W-1]}}, w_shift});
    assign w_abs       = w_shift[FP_SHIFT_W-1] ? FP_SHIFT_W'(-w_shift) : FP_SHIFT_W'(w_shift);
    // MSB of the aligned value lands at bit 23+s; bit OUT_W-1 is the sign.
    assign w_ovr_range = (w_shift_ext + 32'sd23) >= (OUT_W - 1);
    assign w_udr_range = w_shift_ext < -32'sd24;

    always_comb begin
        w_special  = 1'b1;
        w_spec_val = '0;
        w_spec_ovf = 1'b0;
        case (w_class)
            FP_ZERO: begin
                w_spec_val = '0;
            end
            FP_NAN: begin
                w_spec_ovf = 1'b1;
            end
            FP_INF: begin
                w_spec_val = w_sign ? C_SAT_NEG : C_SAT_POS;
                w_spec_ovf = 1'b1;
            end
            default: begin
                if (w_ovr_range) begin
                    w_spec_val = w_sign ? C_SAT_NEG : C_SAT_POS;
                    w_spec_ovf = 1'b1;
                end else if (!w_udr_range) begin
                    w_special = 1'b0;
                end
            end
        endcase
    end

    assign w_accept = in_valid && (r_state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid)     w_state_nxt = SHIFT;
            SHIFT:   if (r_cnt == '0)  w_state_nxt = FINISH;
            FINISH:                    w_state_nxt = DONE;
            DONE:    if (out_ready)    w_state_nxt = IDLE;
            default:                   w_state_nxt = IDLE;
        endcase
    end

`ifdef FP2FIX_ROUND_EN
    logic r_guard;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_guard <= 1'b0;
        end else if (w_accept) begin
            r_guard <= 1'b0;
        end else if ((r_state == SHIFT) && (r_cnt != '0) && !r_left) begin
            r_guard <= r_mag[0];
        end
    end

    // Magnitude is below 2^24 whenever a right shift happened, so no carry-out.
    assign w_mag_fin = r_mag + {{(OUT_W-1){1'b0}}, r_guard};
`else
    assign w_mag_fin = r_mag;
`endif

    assign w_result = r_special ? r_mag : (r_neg ? (~w_mag_fin + 1'b1) : w_mag_fin);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mag     <= '0;
            r_cnt     <= '0;
            r_left    <= 1'b0;
            r_neg     <= 1'b0;
            r_special <= 1'b0;
            r_ovf     <= 1'b0;
        end else if (w_accept) begin
            r_neg     <= w_sign;
            r_left    <= ~w_shift[FP_SHIFT_W-1];
            r_special <= w_special;
            r_ovf     <= w_spec_ovf;
            if (w_special) begin
                r_mag <= w_spec_val;
                r_cnt <= '0;
            end else begin
                r_mag <= {{(OUT_W-FP_MANT_W){1'b0}}, fp_mant(w_frac)};
                r_cnt <= w_abs;
            end
        end else if ((r_state == SHIFT) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
            r_mag <= r_left ? (r_mag << 1) : (r_mag >> 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data <= '0;
            r_out_ovf  <= 1'b0;
        end else if (r_state == FINISH) begin
            r_out_data <= w_result;
            r_out_ovf  <= r_ovf;
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign out_data  = r_out_data;
    assign out_ovf   = r_out_ovf;

endmodule

`default_nettype wire
